// File: rtl/cvxif_copro_responder.sv
// cvxif_copro_responder: CV-X-IF coprocessor that answers offloaded ADD/SUB/XOR
// (opcode 7'h7B, funct7 0) and returns results in issue order.
// Entries are held until commit or kill; killed entries retire silently.
// Optional feature macro: CVXIF_COPRO_MUL_EN adds funct3 3 MUL with a 3-cycle latency.
module cvxif_copro_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned NrEntries = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int unsigned PtrW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [6:0]  OpcCustom = 7'h7B;

  typedef enum logic [2:0] {
    E_FREE,
    E_ISSUED,
    E_EXEC,
    E_DONE,
    E_KILLED
  } entry_state_e;

  entry_state_e          state_q [NrEntries];
  entry_state_e          state_d [NrEntries];
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [IdWidth-1:0]    id_q   [NrEntries];
  logic [4:0]            rd_q   [NrEntries];
  logic                  we_q   [NrEntries];
  logic [XLEN-1:0]       data_q [NrEntries];
`ifdef CVXIF_COPRO_MUL_EN
  logic                  mul_q  [NrEntries];
  logic [1:0]            cnt_q  [NrEntries];
  logic [1:0]            cnt_d  [NrEntries];
`endif

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            dec_ok;
  logic            dec_mul;
  logic [XLEN-1:0] alu_res;
  logic            alloc;
  logic            pop;
  entry_state_e    head_state;
  logic            unused_instr;

  assign opcode       = issue_instr_i[6:0];
  assign rd           = issue_instr_i[11:7];
  assign funct3       = issue_instr_i[14:12];
  assign funct7       = issue_instr_i[31:25];
  assign unused_instr = ^issue_instr_i[24:15];

  // Decode the offered instruction and compute its result up front.
  always_comb begin
    dec_ok  = 1'b0;
    dec_mul = 1'b0;
    alu_res = '0;
    if (opcode == OpcCustom && funct7 == 7'd0) begin
      case (funct3)
        3'd0: begin dec_ok = 1'b1; alu_res = issue_rs1_i + issue_rs2_i; end
        3'd1: begin dec_ok = 1'b1; alu_res = issue_rs1_i - issue_rs2_i; end
        3'd2: begin dec_ok = 1'b1; alu_res = issue_rs1_i ^ issue_rs2_i; end
`ifdef CVXIF_COPRO_MUL_EN
        3'd3: begin dec_ok = 1'b1; dec_mul = 1'b1; alu_res = issue_rs1_i * issue_rs2_i; end
`endif
        default: dec_ok = 1'b0;
      endcase
    end
  end

  assign issue_accept_o    = dec_ok;
  assign issue_writeback_o = dec_ok && (rd != 5'd0);
  assign issue_ready_o     = !rst_i && (occ_q < OccW'(NrEntries));

  assign head_state     = state_q[head_q];
  assign result_valid_o = !rst_i && (head_state == E_DONE);
  assign result_id_o    = rst_i ? '0 : id_q[head_q];
  assign result_data_o  = rst_i ? '0 : data_q[head_q];
  assign result_rd_o    = rst_i ? 5'd0 : rd_q[head_q];
  assign result_we_o    = !rst_i && we_q[head_q];

  assign alloc = issue_valid_i && issue_ready_o && dec_ok;
  assign pop   = (result_valid_o && result_ready_i) || (head_state == E_KILLED);

  // Entry state machines: commit/kill, execution progress, retire and allocate.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
`ifdef CVXIF_COPRO_MUL_EN
    cnt_d   = cnt_q;
`endif
    for (int i = 0; i < NrEntries; i++) begin
      case (state_q[i])
        E_ISSUED: begin
          if (commit_valid_i && id_q[i] == commit_id_i) begin
            state_d[i] = commit_kill_i ? E_KILLED : E_EXEC;
`ifdef CVXIF_COPRO_MUL_EN
            cnt_d[i] = mul_q[i] ? 2'd2 : 2'd0;
`endif
          end
        end
        E_EXEC: begin
`ifdef CVXIF_COPRO_MUL_EN
          if (cnt_q[i] == 2'd0) state_d[i] = E_DONE;
          else                  cnt_d[i]   = cnt_q[i] - 2'd1;
`else
          state_d[i] = E_DONE;
`endif
        end
        default: ;
      endcase
    end
    // Head is DONE/KILLED and tail is FREE, so neither collides with the loop above.
    if (pop) begin
      state_d[head_q] = E_FREE;
      head_d          = head_q + PtrW'(1);
    end
    if (alloc) begin
      state_d[tail_q] = E_ISSUED;
      tail_d          = tail_q + PtrW'(1);
    end
    occ_d = occ_q + OccW'(alloc) - OccW'(pop);
  end

  // State, pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        state_q[i] <= E_FREE;
`ifdef CVXIF_COPRO_MUL_EN
        cnt_q[i]   <= 2'd0;
`endif
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      state_q <= state_d;
`ifdef CVXIF_COPRO_MUL_EN
      cnt_q   <= cnt_d;
`endif
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  // Entry payload captured at allocation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= 5'd0;
        we_q[i]   <= 1'b0;
        data_q[i] <= '0;
`ifdef CVXIF_COPRO_MUL_EN
        mul_q[i]  <= 1'b0;
`endif
      end
    end else if (alloc) begin
      id_q[tail_q]   <= issue_id_i;
      rd_q[tail_q]   <= rd;
      we_q[tail_q]   <= issue_writeback_o;
      data_q[tail_q] <= alu_res;
`ifdef CVXIF_COPRO_MUL_EN
      mul_q[tail_q]  <= dec_mul;
`endif
    end
  end

`ifndef CVXIF_COPRO_MUL_EN
  logic unused_mul;
  assign unused_mul = dec_mul;
`endif

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder (default parameters).
module tb_cvxif_copro_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic [31:0] issue_rs2_i = '0;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cvxif_copro_responder #(.XLEN(32), .IdWidth(4), .NrEntries(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  task automatic set_issue(input logic [31:0] instr, input logic [3:0] id,
                           input logic [31:0] a, input logic [31:0] b);
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
  endtask

  task automatic set_commit(input logic v, input logic [3:0] id, input logic kill);
    commit_valid_i = v;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ready", 64'(issue_ready_o), 64'd0);
    check("rst_valid", 64'(result_valid_o), 64'd0);
    check("rst_data", 64'(result_data_o), 64'd0);
    check("rst_id", 64'(result_id_o), 64'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(issue_ready_o), 64'd1);
    check("post_rst_valid", 64'(result_valid_o), 64'd0);

    // ADD rd=5, 7+3, id=2
    set_issue(enc(7'h7B, 3'd0, 5'd5), 4'd2, 32'd7, 32'd3);
    #1;
    check("add_accept", 64'(issue_accept_o), 64'd1);
    check("add_wb", 64'(issue_writeback_o), 64'd1);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b1, 4'd2, 1'b0);
    #1;
    check("add_valid_c0", 64'(result_valid_o), 64'd0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    check("add_valid_c1", 64'(result_valid_o), 64'd0);
    tick();
    check("add_valid_c2", 64'(result_valid_o), 64'd1);
    check("add_data", 64'(result_data_o), 64'd10);
    check("add_rd", 64'(result_rd_o), 64'd5);
    check("add_we", 64'(result_we_o), 64'd1);
    check("add_id", 64'(result_id_o), 64'd2);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("add_popped", 64'(result_valid_o), 64'd0);

    // SUB 0-1 with rd=0
    set_issue(enc(7'h7B, 3'd1, 5'd0), 4'd5, 32'd0, 32'd1);
    #1;
    check("sub_accept", 64'(issue_accept_o), 64'd1);
    check("sub_wb", 64'(issue_writeback_o), 64'd0);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b1, 4'd5, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("sub_valid", 64'(result_valid_o), 64'd1);
    check("sub_data", 64'(result_data_o), 64'hFFFF_FFFF);
    check("sub_we", 64'(result_we_o), 64'd0);
    check("sub_id", 64'(result_id_o), 64'd5);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;

    // Fill the queue with a rejected opcode interleaved
    set_issue(enc(7'h7B, 3'd0, 5'd1), 4'd4, 32'd104, 32'd4);
    tick();
    set_issue(enc(7'h7B, 3'd2, 5'd1), 4'd5, 32'hF0, 32'h0F);
    tick();
    set_issue(enc(7'h7B, 3'd0, 5'd1), 4'd6, 32'd106, 32'd6);
    tick();
    set_issue(enc(7'h33, 3'd0, 5'd1), 4'd9, 32'd1, 32'd1);
    #1;
    check("bad_opc_accept", 64'(issue_accept_o), 64'd0);
    check("bad_opc_wb", 64'(issue_writeback_o), 64'd0);
    check("three_ready", 64'(issue_ready_o), 64'd1);
    tick();
    set_issue(enc(7'h7B, 3'd0, 5'd1), 4'd7, 32'd107, 32'd7);
    #1;
    check("fourth_ready", 64'(issue_ready_o), 64'd1);
    tick();
    issue_valid_i = 1'b0;
    check("full_ready", 64'(issue_ready_o), 64'd0);
    // Commit with an id that is not in flight
    set_commit(1'b1, 4'd3, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("unknown_commit_valid", 64'(result_valid_o), 64'd0);
    check("unknown_commit_ready", 64'(issue_ready_o), 64'd0);
    set_commit(1'b1, 4'd4, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("full_head_valid", 64'(result_valid_o), 64'd1);
    check("full_head_data", 64'(result_data_o), 64'd108);
    check("full_ready_ignores_rready", 64'(issue_ready_o), 64'd0);
    result_ready_i = 1'b1;
    #1;
    check("full_ready_with_rready", 64'(issue_ready_o), 64'd0);
    tick();
    result_ready_i = 1'b0;
    check("drain_ready", 64'(issue_ready_o), 64'd1);
    // Kill the rest; none may surface
    set_commit(1'b1, 4'd5, 1'b1);
    tick();
    set_commit(1'b1, 4'd6, 1'b1);
    check("kill_drain_v0", 64'(result_valid_o), 64'd0);
    tick();
    set_commit(1'b1, 4'd7, 1'b1);
    check("kill_drain_v1", 64'(result_valid_o), 64'd0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    check("kill_drain_v2", 64'(result_valid_o), 64'd0);
    tick();
    check("kill_drain_v3", 64'(result_valid_o), 64'd0);
    tick();
    check("kill_drain_v4", 64'(result_valid_o), 64'd0);
    check("kill_drain_ready", 64'(issue_ready_o), 64'd1);

    // Out-of-order commit/kill; results stay in issue order
    set_issue(enc(7'h7B, 3'd0, 5'd3), 4'd1, 32'd10, 32'd1);
    tick();
    set_issue(enc(7'h7B, 3'd0, 5'd3), 4'd2, 32'd20, 32'd2);
    tick();
    set_issue(enc(7'h7B, 3'd0, 5'd3), 4'd3, 32'd30, 32'd3);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b1, 4'd3, 1'b0);
    tick();
    set_commit(1'b1, 4'd2, 1'b1);
    tick();
    set_commit(1'b1, 4'd1, 1'b0);
    check("ooo_blocked", 64'(result_valid_o), 64'd0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    check("ooo_wait_head", 64'(result_valid_o), 64'd0);
    tick();
    check("ooo_r1_valid", 64'(result_valid_o), 64'd1);
    check("ooo_r1_id", 64'(result_id_o), 64'd1);
    check("ooo_r1_data", 64'(result_data_o), 64'd11);
    result_ready_i = 1'b1;
    tick();
    check("ooo_killed_hidden", 64'(result_valid_o), 64'd0);
    tick();
    check("ooo_r3_valid", 64'(result_valid_o), 64'd1);
    check("ooo_r3_id", 64'(result_id_o), 64'd3);
    check("ooo_r3_data", 64'(result_data_o), 64'd33);
    tick();
    result_ready_i = 1'b0;
    check("ooo_empty", 64'(result_valid_o), 64'd0);

    // MUL 6*7
    set_issue(enc(7'h7B, 3'd3, 5'd9), 4'd8, 32'd6, 32'd7);
    #1;
`ifdef CVXIF_COPRO_MUL_EN
    check("mul_accept", 64'(issue_accept_o), 64'd1);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b1, 4'd8, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    check("mul_c1", 64'(result_valid_o), 64'd0);
    tick();
    check("mul_c2", 64'(result_valid_o), 64'd0);
    tick();
    check("mul_c3", 64'(result_valid_o), 64'd0);
    tick();
    check("mul_c4", 64'(result_valid_o), 64'd1);
    check("mul_data", 64'(result_data_o), 64'd42);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
`else
    check("mul_accept", 64'(issue_accept_o), 64'd0);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b1, 4'd8, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("mul_no_result", 64'(result_valid_o), 64'd0);
`endif

    // Commit in the allocation cycle is ignored; reset drops a finished entry
    set_issue(enc(7'h7B, 3'd2, 5'd4), 4'd12, 32'hFF00, 32'h0FF0);
    set_commit(1'b1, 4'd12, 1'b0);
    tick();
    issue_valid_i = 1'b0;
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("same_cycle_commit_v1", 64'(result_valid_o), 64'd0);
    tick();
    check("same_cycle_commit_v2", 64'(result_valid_o), 64'd0);
    set_commit(1'b1, 4'd12, 1'b0);
    tick();
    set_commit(1'b0, 4'd0, 1'b0);
    tick();
    check("late_commit_valid", 64'(result_valid_o), 64'd1);
    check("late_commit_data", 64'(result_data_o), 64'h0000_F0F0);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", 64'(result_valid_o), 64'd0);
    check("midrst_ready", 64'(issue_ready_o), 64'd0);
    check("midrst_data", 64'(result_data_o), 64'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("after_rst_valid", 64'(result_valid_o), 64'd0);
    check("after_rst_ready", 64'(issue_ready_o), 64'd1);
    tick(); tick();
    check("after_rst_still_empty", 64'(result_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cvxif_copro_responder.md
CVXIF_COPRO_RESPONDER -- requirements
Module: cvxif_copro_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter IdWidth, default 4, CV-X-IF instruction ID width.
REQ-003 SHALL have parameter NrEntries, default 4, in-flight instruction queue depth (power of 2, >=2).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port issue_valid_i, input, 1, issue request valid.
REQ-007 SHALL have port issue_ready_o, output, 1, responder can take an issue.
REQ-008 SHALL have port issue_instr_i, input, 32, offloaded instruction word.
REQ-009 SHALL have port issue_id_i, input, IdWidth, instruction ID.
REQ-010 SHALL have ports issue_rs1_i and issue_rs2_i, input, XLEN each, source operands.
REQ-011 SHALL have port issue_accept_o, output, 1, instruction accepted (valid with the issue handshake).
REQ-012 SHALL have port issue_writeback_o, output, 1, accepted instruction will write rd.
REQ-013 SHALL have ports commit_valid_i (input, 1), commit_id_i (input, IdWidth) and commit_kill_i (input, 1), the commit/kill notification.
REQ-014 SHALL have ports result_valid_o (output, 1) and result_ready_i (input, 1), the result handshake.
REQ-015 SHALL have ports result_id_o (output, IdWidth), result_data_o (output, XLEN), result_rd_o (output, 5) and result_we_o (output, 1), the result payload.

Function
REQ-016 SHALL accept only opcode 7'h7B with funct7 0 and funct3 0 ADD (rs1+rs2), 1 SUB (rs1-rs2) or 2 XOR; all arithmetic SHALL be mod 2^XLEN.
REQ-017 SHALL drive issue_accept_o and issue_writeback_o combinationally from issue_instr_i; writeback = accept AND rd != 0.
REQ-018 SHALL drive issue_ready_o = (occupancy < NrEntries), independent of result_ready_i in the same cycle.
REQ-019 SHALL complete a non-accepted issue handshake without allocating an entry.
REQ-020 SHALL, on an accepted issue handshake, allocate the tail entry as ISSUED and register id, rd, we and the computed result.
REQ-021 SHALL give each entry the states FREE, ISSUED, EXEC, DONE, KILLED.
REQ-022 SHALL, on commit_valid_i with commit_kill_i=0, move the ISSUED entry whose id equals commit_id_i to EXEC.
REQ-023 SHALL, on commit_valid_i with commit_kill_i=1, move the matching ISSUED entry to KILLED.
REQ-024 SHALL ignore a commit whose id matches no ISSUED entry.
REQ-025 SHALL move an EXEC entry to DONE on the next edge (ALU latency 1).
REQ-026 SHALL present results strictly in issue order from the head entry; result_valid_o = (head state == DONE).
REQ-027 SHALL free the head entry on result_valid_o AND result_ready_i.
REQ-028 SHALL free a KILLED head entry silently, at one entry per cycle, with result_valid_o held 0.
REQ-029 SHALL treat head/tail pointers as wrapping mod NrEntries.
REQ-030 SHALL allow an issue, a commit and a result handshake in the same cycle, each applied independently.
REQ-031 SHALL take a commit targeting an entry allocated in the same cycle effect only if the entry was already ISSUED before that edge.

Reset
REQ-032 SHALL, while rst_i=1, set all entries FREE, pointers and occupancy to 0, and drive result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0 and issue_ready_o=0.
REQ-033 SHALL discard every in-flight instruction, with no result emitted, when rst_i is asserted mid-operation.

Configuration
REQ-034 SHALL, when macro CVXIF_COPRO_MUL_EN is defined, also accept funct3 3 MUL (low XLEN bits of rs1*rs2) with EXEC-to-DONE latency 3 via a per-entry 2-bit countdown.
REQ-035 SHALL, without CVXIF_COPRO_MUL_EN, not accept funct3 3 and contain no multiplier.

Verification
REQ-036 SHALL cover: ADD rd=5, rs1=7, rs2=3, id=2, commit id=2 -> result_valid 2 cycles after commit, data=10, rd=5, we=1.
REQ-037 SHALL cover: SUB rs1=0, rs2=1, rd=0 -> issue_writeback_o=0, data=32'hFFFFFFFF, we=0.
REQ-038 SHALL cover: 4 accepted issues with no commits -> issue_ready_o=0; one result drained -> issue_ready_o=1 the next cycle.
REQ-039 SHALL cover: ids 1,2,3 issued, commit 3, kill 2, commit 1 -> results returned for id 1 then id 3 only, id 2 never visible.
REQ-040 SHALL cover: opcode 7'h33 issued -> accept=0, occupancy unchanged; commit with an unknown id -> no state change.
REQ-041 SHALL cover (CVXIF_COPRO_MUL_EN): MUL 6*7 -> data=42, valid 4 cycles after commit; without the macro -> accept=0.
